// File: rtl/extremum_pkg.sv
// rtl/extremum_pkg.sv - shared state encoding, mode constants and sizing helper for extremum_n
package extremum_pkg;

    typedef enum logic [1:0] {
        START   = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/extremum_n_if.sv
// rtl/extremum_n_if.sv - converter / consumer signal bundle for extremum_n
interface extremum_n_if
    import extremum_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) ();

    localparam int IW = idx_width(N);

    logic            soc;
    logic [N-1:0]    eoc;
    logic [N*W-1:0]  x;
    logic            mode;
    logic            dav_;
    logic            rfd;
    logic [W-1:0]    out;
    logic [IW-1:0]   idx;
    logic            err;

    modport master (
        output soc, dav_, out, idx, err,
        input  eoc, x, mode, rfd
    );

    modport slave (
        input  soc, dav_, out, idx, err,
        output eoc, x, mode, rfd
    );

endinterface

// File: rtl/extremum_tree.sv
// rtl/extremum_tree.sv - combinational N-way unsigned min/max select, lowest index wins ties
module extremum_tree
    import extremum_pkg::*;
#(
    parameter int N  = 3,
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic [N*W-1:0] x,
    input  logic           mode,
    output logic [W-1:0]   value,
    output logic [IW-1:0]  index
);

    logic [W-1:0] cand;
    logic         take;

    // Strict compare only: an equal later channel never displaces an earlier one.
    always_comb begin
        value = x[W-1:0];
        index = '0;
        cand  = '0;
        take  = 1'b0;
        for (int i = 1; i < N; i++) begin
            cand = x[i*W +: W];
            take = (mode == MODE_MIN) ? (cand < value) : (cand > value);
            if (take) begin
                value = cand;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/extremum_n.sv
// rtl/extremum_n.sv - N-channel converter sequencer latching min/max sample with dav_/rfd handshake
module extremum_n
    import extremum_pkg::*;
#(
    parameter int N   = 3,
    parameter int W   = 8,
    parameter int TMO = 255
) (
    input  logic         clock,
    input  logic         reset_,
    extremum_n_if.master bus
);

    localparam int IW = idx_width(N);
    localparam int CW = $clog2(TMO + 1);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic            soc_q;
    logic            dav_q;
    logic            err_q;
    logic [W-1:0]    out_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    sel_value;
    logic [IW-1:0]   sel_index;
    logic            latch;
    logic            timeout;

    extremum_tree #(
        .N  (N),
        .W  (W),
        .IW (IW)
    ) u_tree (
        .x     (bus.x),
        .mode  (bus.mode),
        .value (sel_value),
        .index (sel_index)
    );

    // START waits for soc to be visible before accepting idle eoc, and PRESENT
    // waits for dav_ to be visible before accepting rfd=0, so neither strobe is skipped.
    always_comb begin
        next_state = state;
        latch      = 1'b0;
        timeout    = 1'b0;
        case (state)
            START: begin
                if (soc_q && (bus.eoc == '0)) next_state = WAIT;
            end
            WAIT: begin
                if (&bus.eoc) begin
                    latch      = 1'b1;
                    next_state = PRESENT;
                end else if (cnt == CW'(TMO - 1)) begin
                    timeout    = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (!dav_q && !bus.rfd) next_state = RELEASE;
            end
            RELEASE: begin
                if (bus.rfd) next_state = START;
            end
            default: next_state = START;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= START;
            soc_q <= 1'b0;
            dav_q <= 1'b1;
            out_q <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            soc_q <= (next_state == START);
            // dav_ trails the data latch by one edge so out/idx/err settle first.
            dav_q <= !((state == PRESENT) && (next_state == PRESENT));
            cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (latch) begin
                out_q <= sel_value;
                idx_q <= sel_index;
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.soc  = soc_q;
    assign bus.dav_ = dav_q;
    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.err  = err_q;

endmodule
